// File: rtl/fsm_seq.sv
// Instruction sequencer: fetches pcdata at pc_sel, executes one instruction per cycle
// with counted and event waits. Optional single-step gating via macro FSM_SEQ_STEP_EN.
module fsm_seq #(
    parameter int NUM_IR   = 32,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FSM_SEQ_STEP_EN
    input  logic        step_en,
    input  logic        step,
`endif
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] pcdata,
    input  logic [7:0]  ev_in,
    output logic [7:0]  pc_sel,
    output logic [15:0] ctrl_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SET  = 4'h1;
    localparam logic [3:0] OP_WAIT = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_LDLP = 4'h4;
    localparam logic [3:0] OP_LOOP = 4'h5;
    localparam logic [3:0] OP_WEV  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_PC      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [8:0]       PC_LIMIT = 9'(NUM_IR);
    localparam logic [7:0]       PC_START = 8'(START_PC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAITC,
        S_WAITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_reg;
    logic [7:0]       pc_reg;
    logic [15:0]      ctrl_reg;
    logic [1:0]       err_code_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] loop_cnt_reg;

    logic [3:0]       op;
    logic [3:0]       sub;
    logic [7:0]       tgt;
    logic [CNT_W-1:0] imm;
    logic [8:0]       pc_inc;
    logic             inc_ok;
    logic             tgt_ok;
    logic             ev_hit;
    logic [CNT_W-1:0] loop_dec;
    logic             exec;
    logic             unused_bits;

    assign op          = pcdata[31:28];
    assign sub         = pcdata[27:24];
    assign tgt         = pcdata[23:16];
    assign imm         = CNT_W'(pcdata[15:0]);
    assign unused_bits = sub[3];

    // Range checks are done one bit wider so pc+1 from slot 255 cannot wrap to a legal PC.
    assign pc_inc   = {1'b0, pc_reg} + 9'd1;
    assign inc_ok   = (pc_inc < PC_LIMIT);
    assign tgt_ok   = ({1'b0, tgt} < PC_LIMIT);
    assign ev_hit   = ev_in[sub[2:0]];
    assign loop_dec = loop_cnt_reg - CNT_ONE;

`ifdef FSM_SEQ_STEP_EN
    assign exec = !step_en || step;
`else
    assign exec = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pc_reg       <= PC_START;
            ctrl_reg     <= '0;
            err_code_reg <= '0;
            cnt_reg      <= '0;
            loop_cnt_reg <= '0;
        end else if (abort) begin
            state_reg    <= S_IDLE;
            pc_reg       <= PC_START;
            ctrl_reg     <= '0;
            err_code_reg <= '0;
            cnt_reg      <= '0;
            loop_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (exec) begin
                        case (op)
                            OP_NOP, OP_SET, OP_LDLP: begin
                                if (op == OP_SET)
                                    ctrl_reg <= pcdata[15:0];
                                if (op == OP_LDLP)
                                    loop_cnt_reg <= imm;
                                if (inc_ok) begin
                                    pc_reg <= pc_inc[7:0];
                                end else begin
                                    state_reg    <= S_ERROR;
                                    err_code_reg <= ERR_PC;
                                end
                            end
                            OP_WAIT: begin
                                if (imm != '0) begin
                                    cnt_reg   <= imm - CNT_ONE;
                                    state_reg <= S_WAITC;
                                end else if (inc_ok) begin
                                    pc_reg <= pc_inc[7:0];
                                end else begin
                                    state_reg    <= S_ERROR;
                                    err_code_reg <= ERR_PC;
                                end
                            end
                            OP_JMP: begin
                                if (tgt_ok) begin
                                    pc_reg <= tgt;
                                end else begin
                                    state_reg    <= S_ERROR;
                                    err_code_reg <= ERR_PC;
                                end
                            end
                            OP_LOOP: begin
                                if (loop_cnt_reg != '0)
                                    loop_cnt_reg <= loop_dec;
                                // Branch back only while the decremented count is still non-zero.
                                if (loop_cnt_reg != '0 && loop_dec != '0) begin
                                    if (tgt_ok) begin
                                        pc_reg <= tgt;
                                    end else begin
                                        state_reg    <= S_ERROR;
                                        err_code_reg <= ERR_PC;
                                    end
                                end else if (inc_ok) begin
                                    pc_reg <= pc_inc[7:0];
                                end else begin
                                    state_reg    <= S_ERROR;
                                    err_code_reg <= ERR_PC;
                                end
                            end
                            OP_WEV: begin
                                if (ev_hit) begin
                                    if (inc_ok) begin
                                        pc_reg <= pc_inc[7:0];
                                    end else begin
                                        state_reg    <= S_ERROR;
                                        err_code_reg <= ERR_PC;
                                    end
                                end else begin
                                    cnt_reg   <= imm;
                                    state_reg <= S_WAITE;
                                end
                            end
                            OP_HALT: begin
                                state_reg <= S_DONE;
                            end
                            default: begin
                                state_reg    <= S_ERROR;
                                err_code_reg <= ERR_OPCODE;
                            end
                        endcase
                    end
                end
                S_WAITC: begin
                    if (cnt_reg == '0) begin
                        if (inc_ok) begin
                            pc_reg    <= pc_inc[7:0];
                            state_reg <= S_RUN;
                        end else begin
                            state_reg    <= S_ERROR;
                            err_code_reg <= ERR_PC;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                S_WAITE: begin
                    // pc_sel holds during the wait, so pcdata still carries the WEV word.
                    if (ev_hit) begin
                        if (inc_ok) begin
                            pc_reg    <= pc_inc[7:0];
                            state_reg <= S_RUN;
                        end else begin
                            state_reg    <= S_ERROR;
                            err_code_reg <= ERR_PC;
                        end
                    end else if (imm != '0) begin
                        if (cnt_reg <= CNT_ONE) begin
                            cnt_reg      <= '0;
                            state_reg    <= S_ERROR;
                            err_code_reg <= ERR_TIMEOUT;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_reg    <= S_RUN;
                        pc_reg       <= PC_START;
                        err_code_reg <= '0;
                        loop_cnt_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign pc_sel   = pc_reg;
    assign ctrl_out = ctrl_reg;
    assign err_code = err_code_reg;
    assign busy     = (state_reg == S_RUN) || (state_reg == S_WAITC) || (state_reg == S_WAITE);
    assign done     = (state_reg == S_DONE);
    assign err      = (state_reg == S_ERROR);

endmodule
